brc_seq_cmp: RTL and testbench
==============================

// Module: brc_seq_cmp
// PURPOSE
//  Multi-cycle branch comparator for the area-reduced core: compares two WIDTH-bit
//  register operands CHUNK bits per cycle, MSB chunk first, signed or unsigned.
//  Produces less/equal flags for branch resolution via valid/ready handshakes.
//  Sits between the register-file read and branch-taken logic; trades latency for area.
// PARAMETERS
//  WIDTH  32  operand width; WIDTH % CHUNK == 0 required (elaboration error otherwise)
//  CHUNK   8  bits compared per cycle; 1..WIDTH; CHUNK==WIDTH gives 1-cycle compare
//  NCHUNK derived localparam = WIDTH/CHUNK; counter width $clog2(NCHUNK), min 1
// PORTS
//  i_clk        in   1      clock, rising edge
//  i_rst_n      in   1      asynchronous, active-low reset
//  i_valid      in   1      request valid
//  o_ready      out  1      request accepted when i_valid & o_ready
//  i_br_un      in   1      1 = unsigned compare, 0 = signed (two's complement)
//  i_rs1_data   in   WIDTH  operand A
//  i_rs2_data   in   WIDTH  operand B
//  o_valid      out  1      result valid; held until i_ready
//  i_ready      in   1      result consumed when o_valid & i_ready
//  o_br_less    out  1      A < B under selected signedness
//  o_br_equal   out  1      A == B
// BEHAVIOUR
//  - Reset (async assert): state IDLE, o_valid=0, o_br_less=0, o_br_equal=0, chunk ctr=0;
//    o_ready=1 (decoded from IDLE) while reset held. Reset mid-operation abandons it, no o_valid.
//  - o_ready = (state==IDLE); o_valid = (state==DONE). No queueing; i_valid while !o_ready ignored.
//  - Accept: latch A,B with MSB inverted when i_br_un=0 (maps signed order onto unsigned);
//    ctr <= NCHUNK-1; state IDLE->CMP. Inputs ignored after accept.
//  - CMP, each cycle compares chunk [ctr*CHUNK +: CHUNK]:
//      a<b: less<=1, equal<=0, decided; a>b: less<=0, equal<=0, decided;
//      a==b: if ctr==0 -> less<=0, equal<=1, -> DONE; else ctr<=ctr-1, stay CMP.
//  - DONE: flags stable; if i_ready -> IDLE (o_ready high next cycle). No back-to-back
//    accept in the DONE->IDLE cycle.
//  - Latency: counted in rising edges from accept edge to o_valid high.
//  - Flags are registered; o_br_less and o_br_equal never both 1.
// CONFIGURATION
//  BRC_EARLY_EXIT_EN defined: first differing chunk ends CMP (decided -> DONE);
//    latency = 1-based index of first differing chunk from MSB (1..NCHUNK); equal = NCHUNK.
//  Undefined: decision latched at first difference, later chunks ignored; CMP always runs
//    NCHUNK cycles; latency fixed = NCHUNK for every operand pair.
// STRUCTURE
//  brc_pkg: typedef enum logic [1:0] {BRC_IDLE, BRC_CMP, BRC_DONE} brc_state_e;
//    shared defaults BRC_WIDTH=32, BRC_CHUNK=8.
//  Sub-module brc_chunk_cmp #(CHUNK): combinational unsigned compare, outputs o_lt, o_eq;
//    one instance in brc_seq_cmp. Top holds FSM, operand regs, counter, flag regs.
// TESTING (WIDTH=32, CHUNK=8, run with and without BRC_EARLY_EXIT_EN)
//  1 Assert i_rst_n=0 during 2nd CMP cycle -> o_valid=0, o_ready=1, flags 0; no result after release.
//  2 A=0x0000_0001, B=0xFFFF_FFFF, un=1 -> less=1 eq=0; latency 1 (EN) / 4 (no EN).
//  3 Same operands, un=0 -> less=0 eq=0 (1 > -1); latency 1 / 4.
//  4 A=B=0x8000_0000, un=0 -> less=0 eq=1; latency 4 both builds.
//  5 A=0x1234_5600, B=0x1234_5601, un=1 -> less=1 eq=0, latency 4; A=0x8000_0000,
//    B=0x7FFF_FFFF un=0 -> less=1, latency 1 / 4.
//  6 Hold i_ready=0 5 cycles in DONE, toggle i_valid/operands -> o_valid, flags stable,
//    o_ready=0; raise i_ready -> o_valid=0, o_ready=1 next cycle.

Source files
------------

// File: rtl/brc_pkg.sv
// Shared types and defaults for the sequential branch comparator.
// Optional feature macro used by brc_seq_cmp: BRC_EARLY_EXIT_EN.
package brc_pkg;

  typedef enum logic [1:0] {
    BRC_IDLE,
    BRC_CMP,
    BRC_DONE
  } brc_state_e;

  localparam int BRC_WIDTH = 32;
  localparam int BRC_CHUNK = 8;

  // A one-chunk compare still needs a 1-bit counter.
  function automatic int brc_ctr_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/brc_chunk_cmp.sv
// Combinational unsigned compare of one operand chunk.
module brc_chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_lt,
  output logic             o_eq
);

  assign o_lt = (i_a < i_b);
  assign o_eq = (i_a == i_b);

endmodule

// File: rtl/brc_seq_cmp.sv
// Multi-cycle branch comparator: CHUNK bits per cycle, MSB chunk first, signed/unsigned.
// Build option: define BRC_EARLY_EXIT_EN to finish at the first differing chunk.
module brc_seq_cmp
  import brc_pkg::*;
#(
  parameter int WIDTH = BRC_WIDTH,
  parameter int CHUNK = BRC_CHUNK
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_br_un,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal
);

  localparam int NCHUNK = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CTR_W  = brc_ctr_width(NCHUNK);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("brc_seq_cmp: CHUNK must be in 1..WIDTH and divide WIDTH");
  end

  brc_state_e       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CTR_W-1:0] ctr_reg;
  logic             less_reg;
  logic             equal_reg;
`ifndef BRC_EARLY_EXIT_EN
  logic             decided_reg;
`endif

  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] a_cur;
  logic [CHUNK-1:0] b_cur;
  logic             chunk_lt;
  logic             chunk_eq;

  // Inverting both MSBs maps two's-complement order onto unsigned order.
  assign msb_flip = WIDTH'(~i_br_un) << (WIDTH - 1);

  genvar gi;
  for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    assign a_chunk[gi] = a_reg[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_reg[gi*CHUNK +: CHUNK];
  end

  assign a_cur = a_chunk[ctr_reg];
  assign b_cur = b_chunk[ctr_reg];

  brc_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .i_a  (a_cur),
    .i_b  (b_cur),
    .o_lt (chunk_lt),
    .o_eq (chunk_eq)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= BRC_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      ctr_reg     <= '0;
      less_reg    <= 1'b0;
      equal_reg   <= 1'b0;
`ifndef BRC_EARLY_EXIT_EN
      decided_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        BRC_IDLE: begin
          if (i_valid) begin
            a_reg       <= i_rs1_data ^ msb_flip;
            b_reg       <= i_rs2_data ^ msb_flip;
            ctr_reg     <= CTR_LAST;
            less_reg    <= 1'b0;
            equal_reg   <= 1'b0;
`ifndef BRC_EARLY_EXIT_EN
            decided_reg <= 1'b0;
`endif
            state_reg   <= BRC_CMP;
          end
        end
        BRC_CMP: begin
`ifdef BRC_EARLY_EXIT_EN
          if (!chunk_eq) begin
            less_reg  <= chunk_lt;
            equal_reg <= 1'b0;
            state_reg <= BRC_DONE;
          end else if (ctr_reg == '0) begin
            less_reg  <= 1'b0;
            equal_reg <= 1'b1;
            state_reg <= BRC_DONE;
          end else begin
            ctr_reg <= ctr_reg - 1'b1;
          end
`else
          // Fixed latency: the first difference decides, later chunks are ignored.
          if (!decided_reg) begin
            if (!chunk_eq) begin
              less_reg    <= chunk_lt;
              equal_reg   <= 1'b0;
              decided_reg <= 1'b1;
            end else if (ctr_reg == '0) begin
              less_reg  <= 1'b0;
              equal_reg <= 1'b1;
            end
          end
          if (ctr_reg == '0) begin
            state_reg <= BRC_DONE;
          end else begin
            ctr_reg <= ctr_reg - 1'b1;
          end
`endif
        end
        BRC_DONE: begin
          if (i_ready) begin
            state_reg <= BRC_IDLE;
          end
        end
        default: state_reg <= BRC_IDLE;
      endcase
    end
  end

  assign o_ready    = (state_reg == BRC_IDLE);
  assign o_valid    = (state_reg == BRC_DONE);
  assign o_br_less  = less_reg;
  assign o_br_equal = equal_reg;

endmodule

// File: tb/tb_brc_seq_cmp.sv
// Self-checking bench for brc_seq_cmp (WIDTH=32, CHUNK=8); honours BRC_EARLY_EXIT_EN.
`timescale 1ns/1ps
module tb_brc_seq_cmp;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_br_un = 1'b0;
  logic              i_ready = 1'b0;
  logic [WIDTH-1:0]  i_rs1_data = '0;
  logic [WIDTH-1:0]  i_rs2_data = '0;
  logic              o_ready;
  logic              o_valid;
  logic              o_br_less;
  logic              o_br_equal;

  int total = 0;
  int bad   = 0;

  brc_seq_cmp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_br_un    (i_br_un),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_br_less  (o_br_less),
    .o_br_equal (o_br_equal)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic plus byte-wise scan for latency.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic un,
                       output logic less, output logic eq, output int lat);
    bit found;
    eq   = (a == b);
    less = un ? (a < b) : ($signed(a) < $signed(b));
    lat  = NCHUNK;
`ifdef BRC_EARLY_EXIT_EN
    found = 1'b0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (!found && (((a >> (8*(NCHUNK-1-i))) & 32'hFF) != ((b >> (8*(NCHUNK-1-i))) & 32'hFF))) begin
        found = 1'b1;
        lat   = i + 1;
      end
    end
`else
    found = 1'b0;
`endif
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic un,
                        input int hold, input string tag);
    logic el, ee;
    int   elat, lat, w;
    model(a, b, un, el, ee, elat);
    w = 0;
    while (o_ready !== 1'b1 && w < 40) begin
      @(posedge i_clk); #1; w++;
    end
    @(negedge i_clk);
    i_valid = 1'b1; i_rs1_data = a; i_rs2_data = b; i_br_un = un; i_ready = 1'b0;
    chk({tag, "_ready_idle"}, o_ready, 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_rs1_data = $urandom; i_rs2_data = $urandom; i_br_un = 1'($urandom);
    chk({tag, "_ready_busy"}, o_ready, 0);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge i_clk); #1; lat++;
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_less"}, o_br_less, el);
    chk({tag, "_equal"}, o_br_equal, ee);
    chk({tag, "_excl"}, o_br_less & o_br_equal, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      i_valid = 1'($urandom); i_rs1_data = $urandom; i_rs2_data = $urandom;
      @(posedge i_clk); #1;
      chk({tag, "_hold_valid"}, o_valid, 1);
      chk({tag, "_hold_ready"}, o_ready, 0);
      chk({tag, "_hold_less"}, o_br_less, el);
      chk({tag, "_hold_equal"}, o_br_equal, ee);
    end
    @(negedge i_clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge i_clk); #1;
    chk({tag, "_release_valid"}, o_valid, 0);
    chk({tag, "_release_ready"}, o_ready, 1);
    @(negedge i_clk);
    i_ready = 1'b0;
    $display("op %s a=%08h b=%08h un=%0d less=%0d eq=%0d lat=%0d", tag, a, b, un, o_br_less, o_br_equal, lat);
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    int          k;
    bit          seen;

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_less", o_br_less, 0);
    chk("rst_equal", o_br_equal, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 0, "t2_un");
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 0, "t3_sg");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, "t4_eq");
    run_op(32'h1234_5600, 32'h1234_5601, 1'b1, 0, "t5_lsb");
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, "t5_min");
    run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 5, "t6_hold");

    // Reset during the second CMP cycle abandons the operation.
    @(negedge i_clk);
    i_valid = 1'b1; i_rs1_data = 32'h1122_3344; i_rs2_data = 32'h1122_3344; i_br_un = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    chk("t1_in_cmp_valid", o_valid, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t1_valid", o_valid, 0);
    chk("t1_ready", o_ready, 1);
    chk("t1_less", o_br_less, 0);
    chk("t1_equal", o_br_equal, 0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge i_clk); #1;
      if (o_valid === 1'b1) seen = 1'b1;
    end
    chk("t1_no_result", 32'(seen), 0);
    chk("t1_ready_after", o_ready, 1);
    $display("op t1_reset_abort valid_seen=%0d", seen);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      k  = $urandom_range(0, 4);
      if (k == 4) begin
        rb = ra;
      end else begin
        mask = 32'hFF << (8*k);
        rb   = ra ^ (mask & {$urandom_range(1, 255), $urandom_range(1, 255),
                             $urandom_range(1, 255), $urandom_range(1, 255)});
        if (k > 0 && $urandom_range(0, 1) == 1) begin
          rb = rb ^ ($urandom & ((32'h1 << (8*k)) - 1));
        end
      end
      if (n % 7 == 0) rb = $urandom;
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
